// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter that picks one functional-unit result per cycle
// and registers it onto the single common data bus lane, with valid/ready to the reorder buffer.
module cdb_arbiter #(
    parameter int FU_NUM    = 8,
    parameter int WORD_SIZE = 32,
    parameter int RB_INDEX  = 4,
    localparam int IW       = (FU_NUM > 1) ? $clog2(FU_NUM) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [FU_NUM-1:0]          req,
    input  logic [FU_NUM*WORD_SIZE-1:0] req_data,
    input  logic [FU_NUM*WORD_SIZE-1:0] req_addr,
    input  logic [FU_NUM*RB_INDEX-1:0] req_rb_index,
    output logic [FU_NUM-1:0]          grant,
    output logic                       cdb_valid,
    output logic [WORD_SIZE-1:0]       cdb_data,
    output logic [WORD_SIZE-1:0]       cdb_addr,
    output logic [RB_INDEX-1:0]        cdb_rb_index,
    output logic [IW-1:0]              cdb_fu,
    input  logic                       cdb_ready,
    output logic [15:0]                conflict_cnt
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [IW:0]   FU_N    = (IW + 1)'(FU_NUM);
    localparam logic [IW-1:0] FU_LAST = IW'(FU_NUM - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [IW-1:0]         r_ptr;
    logic [IW-1:0]         r_fu;
    logic [WORD_SIZE-1:0]  r_data;
    logic [WORD_SIZE-1:0]  r_addr;
    logic [RB_INDEX-1:0]   r_rb;
    logic [15:0]           r_conflict;
    logic [IW-1:0]         w_winner;
    logic [IW-1:0]         w_sel;
    logic [IW:0]           w_sum;
    logic                  w_found;
    logic                  w_can_accept;
    logic                  w_fire;
    logic                  w_conflict;
    logic [WORD_SIZE-1:0]  w_data;
    logic [WORD_SIZE-1:0]  w_addr;
    logic [RB_INDEX-1:0]   w_rb;

    assign w_can_accept = !flush && (r_state == EMPTY || cdb_ready);
    assign w_fire       = reset && w_can_accept && w_found;
    assign w_conflict   = reset && w_can_accept && ($countones(req) >= 2);

    // Scan from the round-robin pointer with explicit wrap so non-power-of-2 FU counts work.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        w_sel    = '0;
        for (int k = 0; k < FU_NUM; k++) begin
            w_sum = {1'b0, r_ptr} + (IW + 1)'(k);
            w_sum = (w_sum >= FU_N) ? w_sum - FU_N : w_sum;
            w_sel = w_sum[IW-1:0];
            if (!w_found && req[w_sel]) begin
                w_found  = 1'b1;
                w_winner = w_sel;
            end
        end
    end

    always_comb begin
        w_data = '0;
        w_addr = '0;
        w_rb   = '0;
        for (int k = 0; k < FU_NUM; k++) begin
            if (w_winner == IW'(k)) begin
                w_data = req_data[k*WORD_SIZE +: WORD_SIZE];
                w_addr = req_addr[k*WORD_SIZE +: WORD_SIZE];
                w_rb   = req_rb_index[k*RB_INDEX +: RB_INDEX];
            end
        end
    end

    always_comb begin
        w_state_next = w_fire ? FULL : (flush || cdb_ready) ? EMPTY : r_state;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data     <= '0;
            r_addr     <= '0;
            r_rb       <= '0;
            r_fu       <= '0;
            r_ptr      <= '0;
            r_conflict <= '0;
        end else begin
            if (w_fire) begin
                r_data <= w_data;
                r_addr <= w_addr;
                r_rb   <= w_rb;
                r_fu   <= w_winner;
                r_ptr  <= (w_winner == FU_LAST) ? '0 : w_winner + IW'(1);
            end
            if (w_conflict && r_conflict != 16'hFFFF) begin
                r_conflict <= r_conflict + 16'd1;
            end
        end
    end

    assign grant        = w_fire ? (FU_NUM'(1) << w_winner) : '0;
    assign cdb_valid    = (r_state == FULL);
    assign cdb_data     = r_data;
    assign cdb_addr     = r_addr;
    assign cdb_rb_index = r_rb;
    assign cdb_fu       = r_fu;
    assign conflict_cnt = r_conflict;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and random stimulus against a queue-based reference model;
// a monitor process compares every presented broadcast with the scoreboard front.
module tb_cdb_arbiter;
    localparam int N = 8;
    localparam int W = 32;
    localparam int R = 4;

    typedef struct packed {
        logic [W-1:0] data;
        logic [W-1:0] addr;
        logic [R-1:0] rb;
        logic [2:0]   fu;
    } bc_t;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           flush = 1'b0;
    logic           cdb_ready = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N*W-1:0] req_addr = '0;
    logic [N*R-1:0] req_rb_index = '0;
    logic [N-1:0]   grant;
    logic           cdb_valid;
    logic [W-1:0]   cdb_data;
    logic [W-1:0]   cdb_addr;
    logic [R-1:0]   cdb_rb_index;
    logic [2:0]     cdb_fu;
    logic [15:0]    conflict_cnt;

    logic [N-1:0]   m_req = '0;
    logic [W-1:0]   m_data [N];
    logic [W-1:0]   m_addr [N];
    logic [R-1:0]   m_rb [N];
    bc_t            exp_q[$];
    int             ptr = 0;
    int             m_cnt = 0;
    int             n_pass = 0;
    int             n_chk = 0;
    bit             mon_en = 1'b0;

    cdb_arbiter #(.FU_NUM(N), .WORD_SIZE(W), .RB_INDEX(R)) dut (
        .clk(clk), .reset(reset), .flush(flush), .req(req),
        .req_data(req_data), .req_addr(req_addr), .req_rb_index(req_rb_index),
        .grant(grant), .cdb_valid(cdb_valid), .cdb_data(cdb_data),
        .cdb_addr(cdb_addr), .cdb_rb_index(cdb_rb_index), .cdb_fu(cdb_fu),
        .cdb_ready(cdb_ready), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic post(input int i, input logic [W-1:0] d, input logic [R-1:0] rb);
        m_req[i]  = 1'b1;
        m_data[i] = d;
        m_addr[i] = $urandom;
        m_rb[i]   = rb;
    endtask

    task automatic post_rand(input int i);
        post(i, $urandom, R'($urandom));
    endtask

    task automatic refill();
        for (int i = 0; i < N; i++) if (!m_req[i]) post_rand(i);
    endtask

    // One clock of stimulus; the model decides the winner from the scan rule and
    // records what the lane must show after the edge.
    task automatic step(input logic rn, input logic fl, input logic rd);
        int win;
        logic acc;
        logic [N-1:0] eg;
        bc_t e;
        @(negedge clk);
        reset = rn;
        flush = fl;
        cdb_ready = rd;
        req = m_req;
        for (int i = 0; i < N; i++) begin
            req_data[i*W +: W]     = m_data[i];
            req_addr[i*W +: W]     = m_addr[i];
            req_rb_index[i*R +: R] = m_rb[i];
        end
        #1;
        acc = rn && !fl && (exp_q.size() == 0 || rd);
        win = -1;
        if (acc) for (int k = 0; k < N; k++) if (win < 0 && m_req[(ptr + k) % N]) win = (ptr + k) % N;
        eg = '0;
        if (win >= 0) eg[win] = 1'b1;
        chk("grant", grant, eg);
        if (rn) chk("conflict_cnt", conflict_cnt, m_cnt);
        @(posedge clk);
        if (!rn) begin
            exp_q.delete();
            ptr = 0;
            m_cnt = 0;
        end else begin
            if (acc && $countones(m_req) >= 2 && m_cnt < 65535) m_cnt++;
            if (fl) exp_q.delete();
            if (win >= 0) begin
                e.data = m_data[win];
                e.addr = m_addr[win];
                e.rb   = m_rb[win];
                e.fu   = 3'(win);
                exp_q.push_back(e);
                ptr = (win + 1) % N;
                m_req[win] = 1'b0;
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        #2;
        if (mon_en) begin
            chk("cdb_valid", cdb_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                chk("cdb_data", cdb_data, exp_q[0].data);
                chk("cdb_addr", cdb_addr, exp_q[0].addr);
                chk("cdb_rb_index", cdb_rb_index, exp_q[0].rb);
                chk("cdb_fu", cdb_fu, exp_q[0].fu);
                if (reset && cdb_ready && !flush) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            m_data[i] = '0;
            m_addr[i] = '0;
            m_rb[i]   = '0;
        end
        // Reset held with every FU requesting, then ten cycles of full contention.
        refill();
        step(1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            refill();
            step(1'b1, 1'b0, 1'b1);
        end
        m_req = '0;
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        // Single request from FU3, then FU2+FU4 shows the pointer moved to 4.
        post(3, 32'h1234, 4'd5);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        post_rand(2);
        post_rand(4);
        step(1'b1, 1'b0, 1'b1);
        // Back-pressure: FU2 broadcast held while FU5 waits.
        step(1'b1, 1'b0, 1'b1);
        post_rand(5);
        for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        // Flush with a valid broadcast and FU1 pending.
        post_rand(0);
        step(1'b1, 1'b0, 1'b1);
        post_rand(1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        // Pointer wrap 7 -> 0, then reset while FULL.
        post_rand(6);
        step(1'b1, 1'b0, 1'b1);
        post_rand(7);
        post_rand(0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) if (!m_req[i] && $urandom_range(0, 9) < 3) post_rand(i);
            step($urandom_range(0, 99) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
        end
        step(1'b1, 1'b0, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
